// File: rtl/router_pkg.sv
// Shared router types: flit format, port numbering and the XY routing helpers
// used by the input unit and its FIFO.
package router_pkg;

   localparam int NUM_OF_PORTS = 5;
   localparam int COORD_W      = 4;
   localparam int DATA_W       = 16;

   typedef enum logic [1:0] {
      HEAD      = 2'd0,
      BODY      = 2'd1,
      TAIL      = 2'd2,
      HEAD_TAIL = 2'd3
   } flit_type_t;

   typedef enum logic [2:0] {
      LOCAL     = 3'd0,
      NORTH     = 3'd1,
      EAST      = 3'd2,
      SOUTH     = 3'd3,
      WEST      = 3'd4,
      NONE_PORT = 3'd7
   } port_t;

   typedef enum logic {RX_IDLE, RX_ACKED} rx_state_t;
   typedef enum logic {R_IDLE, R_ACTIVE}  pkt_state_t;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic              valid;
      flit_type_t        flit_type;
      coord_t            dest_x;
      coord_t            dest_y;
      logic [DATA_W-1:0] data;
   } flit_t;

   typedef struct packed {
      flit_t flit;
      port_t target_port;
   } router_pipeline_bus_t;

   function automatic flit_t invalid_flit();
      flit_t f;
      f = '0;
      return f;
   endfunction

   // Dimension-order routing: resolve X completely before moving in Y.
   function automatic port_t xy_route(input coord_t dest_x, input coord_t dest_y,
                                      input coord_t x, input coord_t y);
      if (dest_x > x)      return EAST;
      else if (dest_x < x) return WEST;
      else if (dest_y > y) return NORTH;
      else if (dest_y < y) return SOUTH;
      else                 return LOCAL;
   endfunction

   function automatic logic [NUM_OF_PORTS-1:0] onehot_port(input port_t port);
      logic [NUM_OF_PORTS-1:0] oh;
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
         oh[i] = (port == port_t'(3'(i)));
      end
      return oh;
   endfunction

endpackage

// File: rtl/input_unit_if.sv
// Link-side signal bundle of the input unit: upstream req/ack handshake,
// switch request/accept and status outputs.
interface input_unit_if #(
   parameter int FIFO_DEPTH = 4
);
   import router_pkg::*;

   logic                              i_up_req;
   router_pipeline_bus_t              i_u2i;
   logic                              o_up_ack;
   logic [NUM_OF_PORTS-1:0]           o_switch_request;
   logic [NUM_OF_PORTS-1:0]           i_outport_ack;
   router_pipeline_bus_t              o_i2s;
   logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count;
   logic                              o_err;

   modport master (
      output i_up_req, i_u2i, i_outport_ack,
      input  o_up_ack, o_switch_request, o_i2s, o_fifo_count, o_err
   );

   modport slave (
      input  i_up_req, i_u2i, i_outport_ack,
      output o_up_ack, o_switch_request, o_i2s, o_fifo_count, o_err
   );

endinterface

// File: rtl/input_unit_flit_fifo.sv
// Flit buffer with registered occupancy count; DEPTH must be a power of two so
// the pointers wrap naturally.
module flit_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           push,
   input  flit_t                          push_flit,
   input  logic                           pop,
   output flit_t                          head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   flit_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign count   = count_q;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_flit;
   end

endmodule

// File: rtl/input_unit.sv
// Receive endpoint of an inter-router link: four-phase upstream handshake into
// a flit FIFO, XY route on the head flit, and per-packet streaming to the switch.
module input_unit
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int X_COORD    = 0,
   parameter int Y_COORD    = 0
) (
   input logic          clk,
   input logic          reset_n,
   input_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   rx_state_t               rx_state;
   pkt_state_t              pkt_state;
   logic                    up_ack_q;
   port_t                   target_q;
   logic [NUM_OF_PORTS-1:0] switch_request_q;
   logic                    err_q;

   flit_t                   head;
   logic [CNT_W-1:0]        fifo_count;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    transfer;
   logic                    discard;
   logic                    head_is_start;
   port_t                   route;

   assign route = xy_route(head.dest_x, head.dest_y, coord_t'(X_COORD), coord_t'(Y_COORD));
   assign head_is_start = (head.flit_type == HEAD) || (head.flit_type == HEAD_TAIL);

   // Full is judged on the registered count, so a same-cycle pop never admits a push.
   assign push     = (rx_state == RX_IDLE) && bus.i_up_req && !full && bus.i_u2i.flit.valid;
   assign transfer = (pkt_state == R_ACTIVE) && !empty && |(bus.i_outport_ack & switch_request_q);
   assign discard  = (pkt_state == R_IDLE) && !empty && !head_is_start;
   assign pop      = transfer || discard;

   flit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_flit (bus.i_u2i.flit),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state <= RX_IDLE;
         up_ack_q <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: if (bus.i_up_req && !full) begin
               up_ack_q <= 1'b1;
               rx_state <= RX_ACKED;
            end
            RX_ACKED: if (!bus.i_up_req) begin
               up_ack_q <= 1'b0;
               rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_state        <= R_IDLE;
         target_q         <= NONE_PORT;
         switch_request_q <= '0;
         err_q            <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (pkt_state)
            R_IDLE: if (!empty) begin
               if (head_is_start) begin
                  target_q         <= route;
                  switch_request_q <= onehot_port(route);
                  pkt_state        <= R_ACTIVE;
               end else begin
                  err_q <= 1'b1;
               end
            end
            R_ACTIVE: if (transfer) begin
               // A stray HEAD mid-packet is flagged but still forwarded as a body flit.
               if (head.flit_type == HEAD) err_q <= 1'b1;
               if (head.flit_type == TAIL || head.flit_type == HEAD_TAIL) begin
                  pkt_state        <= R_IDLE;
                  target_q         <= NONE_PORT;
                  switch_request_q <= '0;
               end
            end
            default: pkt_state <= R_IDLE;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      bus.o_i2s.flit        = invalid_flit();
      bus.o_i2s.target_port = target_q;
      if (!empty) begin
         bus.o_i2s.flit       = head;
         bus.o_i2s.flit.valid = 1'b1;
      end
   end

   assign bus.o_up_ack         = up_ack_q;
   assign bus.o_switch_request = switch_request_q;
   assign bus.o_fifo_count     = fifo_count;
   assign bus.o_err            = err_q;

endmodule

// File: tb/tb_input_unit.sv
// Scoreboard bench for input_unit at router (1,1), FIFO_DEPTH=4: upstream flits
// are queued as they are accepted and compared as the switch takes them.
module tb_input_unit;
   import router_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   flit_t sb[$];

   input_unit_if #(.FIFO_DEPTH(4)) bus ();

   input_unit #(.FIFO_DEPTH(4), .X_COORD(1), .Y_COORD(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic flit_t mk(input flit_type_t t, input int dx, input int dy, input int d);
      flit_t f;
      f.valid     = 1'b1;
      f.flit_type = t;
      f.dest_x    = coord_t'(dx);
      f.dest_y    = coord_t'(dy);
      f.data      = DATA_W'(d);
      return f;
   endfunction

   task automatic send_flit(input flit_t f, input bit forward);
      int waited;
      @(negedge clk);
      bus.i_up_req = 1'b1;
      bus.i_u2i    = '{flit: f, target_port: NONE_PORT};
      @(negedge clk);
      n_checks++;
      if (bus.o_up_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_rise: ack=%b required 1", bus.o_up_ack);
         waited = 0;
         while (bus.o_up_ack !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
      end
      if (forward) sb.push_back(f);
      bus.i_up_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_up_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_fall: ack=%b required 0", bus.o_up_ack);
      end
   endtask

   task automatic drain(input port_t port, input logic [4:0] req_exp, input int n, input bit toggle);
      int    done = 0;
      bit    phase = 1'b1;
      flit_t exp_flit;
      while (done < n) begin
         n_checks++;
         if (bus.o_switch_request !== req_exp) begin
            n_fail++;
            $display("FAIL drain_request: req=%b required %b", bus.o_switch_request, req_exp);
         end
         if (!toggle || phase) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL drain_scoreboard: queue empty, required a pending flit");
            end else begin
               exp_flit = sb.pop_front();
               if (bus.o_i2s.flit !== exp_flit || bus.o_i2s.target_port !== port) begin
                  n_fail++;
                  $display("FAIL drain_flit: got %h/%0d required %h/%0d",
                           bus.o_i2s.flit, bus.o_i2s.target_port, exp_flit, port);
               end
            end
            bus.i_outport_ack = req_exp;
            done++;
         end else begin
            bus.i_outport_ack = '0;
         end
         phase = !phase;
         @(negedge clk);
      end
      bus.i_outport_ack = '0;
      n_checks++;
      if (bus.o_switch_request !== 5'b00000 || bus.o_fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL drain_end: req=%b count=%0d required 00000/0",
                  bus.o_switch_request, bus.o_fifo_count);
      end
   endtask

   task automatic test_reset();
      bus.i_up_req      = 1'b0;
      bus.i_u2i         = '{flit: invalid_flit(), target_port: NONE_PORT};
      bus.i_outport_ack = '0;
      @(negedge clk);
      n_checks++;
      if (bus.o_up_ack !== 1'b0 || bus.o_switch_request !== 5'b0 || bus.o_fifo_count !== 3'd0
          || bus.o_err !== 1'b0 || bus.o_i2s.flit !== invalid_flit()
          || bus.o_i2s.target_port !== NONE_PORT) begin
         n_fail++;
         $display("FAIL reset_state: ack=%b req=%b count=%0d err=%b i2s=%h",
                  bus.o_up_ack, bus.o_switch_request, bus.o_fifo_count, bus.o_err, bus.o_i2s);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single_head_tail();
      send_flit(mk(HEAD_TAIL, 3, 1, 'hA1), 1'b1);
      n_checks++;
      if (bus.o_switch_request !== 5'b00100) begin
         n_fail++;
         $display("FAIL single_request: req=%b required 00100", bus.o_switch_request);
      end
      drain(EAST, 5'b00100, 1, 1'b0);
   endtask

   task automatic test_four_flit();
      send_flit(mk(HEAD, 1, 0, 'h101), 1'b1);
      send_flit(mk(BODY, 1, 0, 'h102), 1'b1);
      send_flit(mk(BODY, 1, 0, 'h103), 1'b1);
      send_flit(mk(TAIL, 1, 0, 'h104), 1'b1);
      n_checks++;
      if (bus.o_switch_request !== 5'b01000 || bus.o_fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL four_buffered: req=%b count=%0d required 01000/4",
                  bus.o_switch_request, bus.o_fifo_count);
      end
      drain(SOUTH, 5'b01000, 4, 1'b1);
   endtask

   task automatic test_full();
      flit_t tail_flit;
      flit_t exp_flit;
      send_flit(mk(HEAD, 2, 1, 'h201), 1'b1);
      for (int i = 0; i < 3; i++) send_flit(mk(BODY, 2, 1, 'h202 + i), 1'b1);
      tail_flit = mk(TAIL, 2, 1, 'h20F);
      bus.i_up_req = 1'b1;
      bus.i_u2i    = '{flit: tail_flit, target_port: NONE_PORT};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.o_up_ack !== 1'b0 || bus.o_fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_hold: ack=%b count=%0d required 0/4", bus.o_up_ack, bus.o_fifo_count);
         end
      end
      exp_flit = sb.pop_front();
      n_checks++;
      if (bus.o_i2s.flit !== exp_flit) begin
         n_fail++;
         $display("FAIL full_pop_flit: got %h required %h", bus.o_i2s.flit, exp_flit);
      end
      bus.i_outport_ack = 5'b00100;
      @(negedge clk);
      bus.i_outport_ack = '0;
      sb.push_back(tail_flit);
      n_checks++;
      if (bus.o_fifo_count !== 3'd3 || bus.o_up_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL full_after_pop: count=%0d ack=%b required 3/0", bus.o_fifo_count, bus.o_up_ack);
      end
      @(negedge clk);
      n_checks++;
      if (bus.o_fifo_count !== 3'd4 || bus.o_up_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL full_refill: count=%0d ack=%b required 4/1", bus.o_fifo_count, bus.o_up_ack);
      end
      bus.i_up_req = 1'b0;
      @(negedge clk);
      drain(EAST, 5'b00100, 4, 1'b0);
   endtask

   task automatic test_stray_body();
      send_flit(mk(BODY, 3, 3, 'h301), 1'b0);
      n_checks++;
      if (bus.o_err !== 1'b1 || bus.o_fifo_count !== 3'd0 || bus.o_switch_request !== 5'b0) begin
         n_fail++;
         $display("FAIL stray_err: err=%b count=%0d req=%b required 1/0/00000",
                  bus.o_err, bus.o_fifo_count, bus.o_switch_request);
      end
      @(negedge clk);
      n_checks++;
      if (bus.o_err !== 1'b0 || bus.o_switch_request !== 5'b0) begin
         n_fail++;
         $display("FAIL stray_once: err=%b req=%b required 0/00000", bus.o_err, bus.o_switch_request);
      end
   endtask

   task automatic test_local_wrong_port();
      send_flit(mk(HEAD_TAIL, 1, 1, 'h401), 1'b1);
      n_checks++;
      if (bus.o_switch_request !== 5'b00001) begin
         n_fail++;
         $display("FAIL local_request: req=%b required 00001", bus.o_switch_request);
      end
      bus.i_outport_ack = 5'b01000;
      @(negedge clk);
      @(negedge clk);
      bus.i_outport_ack = '0;
      n_checks++;
      if (bus.o_fifo_count !== 3'd1 || bus.o_switch_request !== 5'b00001) begin
         n_fail++;
         $display("FAIL wrong_port: count=%0d req=%b required 1/00001",
                  bus.o_fifo_count, bus.o_switch_request);
      end
      drain(LOCAL, 5'b00001, 1, 1'b0);
   endtask

   task automatic test_reset_mid_packet();
      send_flit(mk(HEAD, 3, 1, 'h501), 1'b1);
      send_flit(mk(BODY, 3, 1, 'h502), 1'b1);
      n_checks++;
      if (bus.o_fifo_count !== 3'd2 || bus.o_switch_request !== 5'b00100) begin
         n_fail++;
         $display("FAIL midreset_setup: count=%0d req=%b required 2/00100",
                  bus.o_fifo_count, bus.o_switch_request);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (bus.o_up_ack !== 1'b0 || bus.o_switch_request !== 5'b0 || bus.o_fifo_count !== 3'd0
          || bus.o_err !== 1'b0 || bus.o_i2s.flit !== invalid_flit()
          || bus.o_i2s.target_port !== NONE_PORT) begin
         n_fail++;
         $display("FAIL midreset_async: ack=%b req=%b count=%0d err=%b i2s=%h",
                  bus.o_up_ack, bus.o_switch_request, bus.o_fifo_count, bus.o_err, bus.o_i2s);
      end
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.o_fifo_count !== 3'd0 || bus.o_switch_request !== 5'b0) begin
         n_fail++;
         $display("FAIL midreset_release: count=%0d req=%b required 0/00000",
                  bus.o_fifo_count, bus.o_switch_request);
      end
      send_flit(mk(HEAD_TAIL, 1, 2, 'h5AA), 1'b1);
      n_checks++;
      if (bus.o_switch_request !== 5'b00010) begin
         n_fail++;
         $display("FAIL midreset_route: req=%b required 00010", bus.o_switch_request);
      end
      drain(NORTH, 5'b00010, 1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_head_tail();
      test_four_flit();
      test_full();
      test_stray_body();
      test_local_wrong_port();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
